// File: rtl/sm_accumulator.sv
// rtl/sm_accumulator.sv - sign-magnitude frame accumulator with valid/ready result port
// Optional build macro SM_SAT_EN: saturate the accumulator on signed overflow instead of wrapping.
module sm_accumulator #(
   parameter int WIDTH = 4,
   parameter int ACC_W = 8,
   parameter int COUNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_neg,
   input  logic [WIDTH-1:0] in_mag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf,
   output logic             busy
);
   localparam int CW = $clog2(COUNT + 1);
   localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, acc_nxt, mag_ext, v, sum_raw, sum_add;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             ovf, ovf_nxt, ovf_now, accept;

   assign in_ready = (state != DONE);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;

   // -0 negates to 0, so it needs no special case
   assign mag_ext = {{(ACC_W - WIDTH){1'b0}}, in_mag};
   assign v       = in_neg ? -mag_ext : mag_ext;
   assign sum_raw = acc + v;
   assign ovf_now = (acc[ACC_W-1] == v[ACC_W-1]) && (sum_raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef SM_SAT_EN
   localparam logic [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
   localparam logic [ACC_W-1:0] NEG_MIN = {1'b1, {(ACC_W - 1){1'b0}}};
   assign sum_add = ovf_now ? (v[ACC_W-1] ? NEG_MIN : POS_MAX) : sum_raw;
`else
   assign sum_add = sum_raw;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      case (state)
         IDLE: begin
            if (accept) begin
               acc_nxt   = v;
               cnt_nxt   = CW'(1);
               ovf_nxt   = 1'b0;
               state_nxt = (COUNT == 1) ? DONE : ACC;
            end
         end
         ACC: begin
            if (accept) begin
               acc_nxt = sum_add;
               cnt_nxt = cnt + 1'b1;
               ovf_nxt = ovf | ovf_now;
               if (cnt == LAST) state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               acc_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // result registers load once on entry to DONE and hold through backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
      end else begin
         acc       <= acc_nxt;
         cnt       <= cnt_nxt;
         ovf       <= ovf_nxt;
         out_valid <= (state_nxt == DONE);
         if (state != DONE && state_nxt == DONE) begin
            out_sum <= acc_nxt;
            out_ovf <= ovf_nxt;
         end
      end
   end
endmodule

// File: tb/tb_sm_accumulator.sv
// tb/tb_sm_accumulator.sv - randomized self-checking bench for sm_accumulator
// Drives an 8-bit and a 6-bit accumulator in lockstep against an integer reference model.
module tb_sm_accumulator;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       in_valid = 1'b0, in_neg = 1'b0, out_ready = 1'b0;
   logic [3:0] in_mag = 4'd0;
   logic       in_ready, out_valid, out_ovf, busy;
   logic [7:0] out_sum;
   logic       in_ready6, out_valid6, out_ovf6, busy6;
   logic [5:0] out_sum6;

   int         vectors = 0, miscompares = 0;
   logic       fneg [4];
   logic [3:0] fmag [4];
   int         fgap [4];

   always #5 clk = ~clk;

   sm_accumulator dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_neg(in_neg), .in_mag(in_mag), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
   );

   sm_accumulator #(.WIDTH(4), .ACC_W(6), .COUNT(4)) dut6 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
      .in_neg(in_neg), .in_mag(in_mag), .out_valid(out_valid6), .out_ready(out_ready),
      .out_sum(out_sum6), .out_ovf(out_ovf6), .busy(busy6)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // frame total as a plain signed integer, folded back into range on overflow
   function automatic void model(input int w, output logic [31:0] sum, output logic [31:0] ovf);
      int s, v, mx, mn;
      mx  = (1 << (w - 1)) - 1;
      mn  = -(1 << (w - 1));
      s   = 0;
      ovf = 0;
      for (int i = 0; i < 4; i++) begin
         v = fneg[i] ? -int'(fmag[i]) : int'(fmag[i]);
         s = s + v;
         if (s > mx || s < mn) begin
            ovf = 1;
`ifdef SM_SAT_EN
            s = (s > mx) ? mx : mn;
`else
            s = (s > mx) ? s - (1 << w) : s + (1 << w);
`endif
         end
      end
      sum = 32'(s & ((1 << w) - 1));
   endfunction

   task automatic set_word(input int i, input logic n, input logic [3:0] m, input int g);
      fneg[i] = n;
      fmag[i] = m;
      fgap[i] = g;
   endtask

   task automatic check_idle_state(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_valid6"}, 32'(out_valid6), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_frame(input int hold, input bit force_valid);
      logic [31:0] es8, eo8, es6, eo6;
      model(8, es8, eo8);
      model(6, es6, eo6);
      for (int i = 0; i < 4; i++) begin
         repeat (fgap[i]) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("gap_valid", 32'(out_valid), 32'd0);
         end
         @(negedge clk);
         check("pre_valid", 32'(out_valid), 32'd0);
         check("pre_in_ready", 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_neg   = fneg[i];
         in_mag   = fmag[i];
      end
      @(negedge clk);
      check("done_valid", 32'(out_valid), 32'd1);
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("done_busy", 32'(busy), 32'd1);
      check("sum8", 32'(out_sum), es8);
      check("ovf8", 32'(out_ovf), eo8);
      check("done_valid6", 32'(out_valid6), 32'd1);
      check("sum6", 32'(out_sum6), es6);
      check("ovf6", 32'(out_ovf6), eo6);
      for (int c = 0; c <= hold; c++) begin
         in_valid = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
         in_neg   = 1'($urandom);
         in_mag   = 4'($urandom);
         if (c < hold) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum8", 32'(out_sum), es8);
            check("hold_sum6", 32'(out_sum6), es6);
            check("hold_ovf6", 32'(out_ovf6), eo6);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_idle_state("handoff");
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   initial begin
      #2;
      check_idle_state("reset");
      check("reset_sum", 32'(out_sum), 32'd0);
      check("reset_ovf", 32'(out_ovf), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // +3,+5,-2,-0 back to back
      set_word(0, 0, 3, 0); set_word(1, 0, 5, 0); set_word(2, 1, 2, 0); set_word(3, 1, 0, 0);
      run_frame(0, 0);
      // -15 x4
      for (int i = 0; i < 4; i++) set_word(i, 1, 15, 0);
      run_frame(0, 0);
      // +15 x4 overflows the 6-bit instance
      for (int i = 0; i < 4; i++) set_word(i, 0, 15, 0);
      run_frame(1, 0);
      // backpressure for 5 cycles with input traffic present
      set_word(0, 0, 1, 0); set_word(1, 1, 2, 0); set_word(2, 0, 3, 0); set_word(3, 0, 4, 0);
      run_frame(5, 1);
      // +7 x4 with idle gaps between words
      set_word(0, 0, 7, 0); set_word(1, 0, 7, 3); set_word(2, 0, 7, 3); set_word(3, 0, 7, 3);
      run_frame(0, 0);

      // reset after two accepted words discards the partial sum
      @(negedge clk);
      in_valid = 1'b1; in_neg = 1'b0; in_mag = 4'd5;
      @(negedge clk);
      in_mag = 4'd9;
      @(negedge clk);
      in_valid = 1'b0;
      check("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_idle_state("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) set_word(i, 0, 1, 0);
      run_frame(0, 0);

      for (int f = 0; f < 20; f++) begin
         for (int i = 0; i < 4; i++)
            set_word(i, 1'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
         run_frame(int'($urandom_range(0, 3)), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
